// File: rtl/vec_stim_check_i8.sv
// Self-checking stimulus sequencer: drives LFSR operand pairs into a two-operand
// 8-bit DUT, delays the golden result by LATENCY cycles and checks the DUT result.
module vec_stim_check_i8 #(
    parameter int          OP      = 0,
    parameter int          LATENCY = 0,
    parameter int          NUM_VEC = 16,
    parameter logic [7:0]  SEED_A  = 8'h09,
    parameter logic [7:0]  SEED_B  = 8'h0F
) (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  a,
    output logic [7:0]  b,
    input  logic [7:0]  y,
    output logic        fail,
    output logic        finish,
    output logic [7:0]  err_count,
    output logic [15:0] first_err_idx,
    output logic [1:0]  state_dbg
);

    localparam logic [7:0]  INIT_A   = (SEED_A == 8'h00) ? 8'h01 : SEED_A;
    localparam logic [7:0]  INIT_B   = (SEED_B == 8'h00) ? 8'h01 : SEED_B;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] vec_cnt_q;
    logic [7:0]  a_q, b_q;

    logic        push;
    logic        last_vec;
    logic [7:0]  exp_now;
    logic        chk_valid;
    logic [7:0]  chk_exp;
    logic [15:0] chk_idx;
    logic        do_check;
    logic        chk_done;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [7:0] golden(input logic [7:0] x, input logic [7:0] z);
        case (OP)
            0:       return x & z;
            1:       return x | z;
            2:       return x ^ z;
            3:       return x + z;
            4:       return x - z;
            default: return 8'h00;
        endcase
    endfunction

    assign a        = a_q;
    assign b        = b_q;
    assign push     = (state_q == S_RUN);
    assign last_vec = (vec_cnt_q == LAST_IDX);
    assign exp_now  = golden(a_q, b_q);

    // Delay line: the expected value and its vector index travel together.
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign chk_valid = push;
            assign chk_exp   = exp_now;
            assign chk_idx   = vec_cnt_q;
        end else begin : g_delay
            logic [LATENCY-1:0] dl_valid;
            logic [7:0]         dl_exp [LATENCY];
            logic [15:0]        dl_idx [LATENCY];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dl_valid <= '0;
                    for (int j = 0; j < LATENCY; j++) begin
                        dl_exp[j] <= 8'h00;
                        dl_idx[j] <= 16'h0000;
                    end
                end else begin
                    dl_valid[0] <= push;
                    dl_exp[0]   <= exp_now;
                    dl_idx[0]   <= vec_cnt_q;
                    for (int j = 1; j < LATENCY; j++) begin
                        dl_valid[j] <= dl_valid[j-1];
                        dl_exp[j]   <= dl_exp[j-1];
                        dl_idx[j]   <= dl_idx[j-1];
                    end
                end
            end

            assign chk_valid = dl_valid[LATENCY-1];
            assign chk_exp   = dl_exp[LATENCY-1];
            assign chk_idx   = dl_idx[LATENCY-1];
        end
    endgenerate

    assign do_check = chk_valid && (state_q != S_DONE);
    assign chk_done = do_check && (chk_idx == LAST_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (chk_done)      state_d = S_DONE;
                else if (last_vec) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (chk_done)      state_d = S_DONE;
            end
            default: state_d = S_DONE;
        endcase
    end

    // Operands hold on the last vector so the DUT sees stable inputs while draining.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            vec_cnt_q <= 16'h0000;
            a_q       <= INIT_A;
            b_q       <= INIT_B;
        end else begin
            state_q <= state_d;
            if (push && !last_vec) begin
                vec_cnt_q <= vec_cnt_q + 16'h0001;
                a_q       <= lfsr_next(a_q);
                b_q       <= lfsr_next(b_q);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fail          <= 1'b0;
            err_count     <= 8'h00;
            first_err_idx <= 16'h0000;
        end else if (do_check && (y != chk_exp)) begin
            fail <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'h01;
            if (!fail)              first_err_idx <= chk_idx;
        end
    end

    assign finish    = (state_q == S_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vec_stim_check_i8.sv
// Directed bench: several sequencer instances, each wired to a small behavioural DUT.
module tb_vec_stim_check_i8;

    logic clock = 1'b0;
    logic rst_main;
    logic rst_mid;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [7:0]  a_s   [7];
    logic [7:0]  b_s   [7];
    logic [7:0]  y_s   [7];
    logic        fail_s[7];
    logic        fin_s [7];
    logic [7:0]  err_s [7];
    logic [15:0] idx_s [7];
    logic [1:0]  st_s  [7];

    logic [7:0] r2a, r2b, r3a;
    int         cyc;
    int         exp_first;

    always #5 clock = ~clock;

    // 0: and single vector, 1: xor with fault on vector 3, 2: 2-stage adder,
    // 3: adder DUT one stage short, 4: sub with y tied low, 5: zero seeds, 6: mid-run reset
    vec_stim_check_i8 #(.OP(0), .LATENCY(0), .NUM_VEC(1)) u0 (
        .clock(clock), .reset(rst_main), .a(a_s[0]), .b(b_s[0]), .y(y_s[0]), .fail(fail_s[0]),
        .finish(fin_s[0]), .err_count(err_s[0]), .first_err_idx(idx_s[0]), .state_dbg(st_s[0]));
    vec_stim_check_i8 #(.OP(2), .LATENCY(0), .NUM_VEC(8)) u1 (
        .clock(clock), .reset(rst_main), .a(a_s[1]), .b(b_s[1]), .y(y_s[1]), .fail(fail_s[1]),
        .finish(fin_s[1]), .err_count(err_s[1]), .first_err_idx(idx_s[1]), .state_dbg(st_s[1]));
    vec_stim_check_i8 #(.OP(3), .LATENCY(2), .NUM_VEC(4)) u2 (
        .clock(clock), .reset(rst_main), .a(a_s[2]), .b(b_s[2]), .y(y_s[2]), .fail(fail_s[2]),
        .finish(fin_s[2]), .err_count(err_s[2]), .first_err_idx(idx_s[2]), .state_dbg(st_s[2]));
    vec_stim_check_i8 #(.OP(3), .LATENCY(2), .NUM_VEC(4)) u3 (
        .clock(clock), .reset(rst_main), .a(a_s[3]), .b(b_s[3]), .y(y_s[3]), .fail(fail_s[3]),
        .finish(fin_s[3]), .err_count(err_s[3]), .first_err_idx(idx_s[3]), .state_dbg(st_s[3]));
    vec_stim_check_i8 #(.OP(4), .LATENCY(0), .NUM_VEC(300)) u4 (
        .clock(clock), .reset(rst_main), .a(a_s[4]), .b(b_s[4]), .y(y_s[4]), .fail(fail_s[4]),
        .finish(fin_s[4]), .err_count(err_s[4]), .first_err_idx(idx_s[4]), .state_dbg(st_s[4]));
    vec_stim_check_i8 #(.OP(0), .LATENCY(0), .NUM_VEC(16), .SEED_A(8'h00), .SEED_B(8'h00)) u5 (
        .clock(clock), .reset(rst_main), .a(a_s[5]), .b(b_s[5]), .y(y_s[5]), .fail(fail_s[5]),
        .finish(fin_s[5]), .err_count(err_s[5]), .first_err_idx(idx_s[5]), .state_dbg(st_s[5]));
    vec_stim_check_i8 #(.OP(1), .LATENCY(0), .NUM_VEC(16)) u6 (
        .clock(clock), .reset(rst_mid), .a(a_s[6]), .b(b_s[6]), .y(y_s[6]), .fail(fail_s[6]),
        .finish(fin_s[6]), .err_count(err_s[6]), .first_err_idx(idx_s[6]), .state_dbg(st_s[6]));

    assign y_s[0] = a_s[0] & b_s[0];
    assign y_s[1] = (cyc == 3) ? 8'h00 : (a_s[1] ^ b_s[1]);
    assign y_s[2] = r2b;
    assign y_s[3] = r3a;
    assign y_s[4] = 8'h00;
    assign y_s[5] = a_s[5] & b_s[5];
    assign y_s[6] = a_s[6] | b_s[6];

    always @(posedge clock) begin
        r2a <= a_s[2] + b_s[2];
        r2b <= r2a;
        r3a <= a_s[3] + b_s[3];
    end

    function automatic logic [7:0] model_lfsr(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        logic [7:0] ma, mb;
        ma = 8'h09;
        mb = 8'h0F;
        exp_first = -1;
        for (int i = 0; i < 300; i++) begin
            if (exp_first < 0 && ma != mb) exp_first = i;
            ma = model_lfsr(ma);
            mb = model_lfsr(mb);
        end

        cyc      = 0;
        rst_main = 1'b1;
        rst_mid  = 1'b1;
        #12;
        check_val("rst_a",      a_s[0],   8'h09);
        check_val("rst_b",      b_s[0],   8'h0F);
        check_val("rst_fail",   fail_s[0], 1'b0);
        check_val("rst_finish", fin_s[0], 1'b0);
        check_val("rst_err",    err_s[0], 8'h00);
        check_val("rst_idx",    idx_s[0], 16'h0000);
        check_val("rst_state",  st_s[0],  2'd0);
        check_val("rst_a_zero", a_s[5],   8'h01);
        check_val("rst_b_zero", b_s[5],   8'h01);
        rst_main = 1'b0;
        rst_mid  = 1'b0;
        check_val("lfsr_a_c0", a_s[6], 8'h09);

        for (int k = 0; k < 310; k++) begin
            tick();
            if (k == 0) begin
                check_val("single_finish", fin_s[0], 1'b1);
                check_val("single_fail",   fail_s[0], 1'b0);
                check_val("single_err",    err_s[0], 8'h00);
                check_val("single_a_hold", a_s[0],   8'h09);
                check_val("lfsr_a_c1",     a_s[6],   8'hBC);
                check_val("lfsr_b_c1",     b_s[6],   8'hBF);
                check_val("zero_a_c1",     a_s[5],   8'hB8);
                check_val("zero_b_c1",     b_s[5],   8'hB8);
            end
            if (k == 1) check_val("lfsr_a_c2", a_s[6], 8'h5E);
            if (k == 2) check_val("lfsr_a_c3", a_s[6], 8'h2F);
            if (k == 3) check_val("lat_state_drain", st_s[2], 2'd1);
            if (k == 4) check_val("lat_finish_early", fin_s[2], 1'b0);
            if (k == 5) begin
                check_val("lat_finish",    fin_s[2],  1'b1);
                check_val("lat_fail",      fail_s[2], 1'b0);
                check_val("lat_short_fail", fail_s[3], 1'b1);
                check_val("lat_short_idx", idx_s[3],  16'h0000);
            end
            if (k == 6) check_val("inj_finish_early", fin_s[1], 1'b0);
            if (k == 7) begin
                check_val("inj_finish", fin_s[1],  1'b1);
                check_val("inj_fail",   fail_s[1], 1'b1);
                check_val("inj_err",    err_s[1],  8'h01);
                check_val("inj_idx",    idx_s[1],  16'h0003);
            end
            if (k == 15) begin
                check_val("or_finish", fin_s[6],  1'b1);
                check_val("or_fail",   fail_s[6], 1'b0);
            end
            if (k == 298) check_val("sat_finish_early", fin_s[4], 1'b0);
            if (k == 299) begin
                check_val("sat_finish", fin_s[4], 1'b1);
                check_val("sat_err",    err_s[4], 8'hFF);
                check_val("sat_idx",    idx_s[4], 16'(exp_first));
            end
            if (k == 309) begin
                check_val("sat_err_frozen", err_s[4],  8'hFF);
                check_val("inj_err_frozen", err_s[1],  8'h01);
                check_val("zero_fail",      fail_s[5], 1'b0);
            end
        end

        // Mid-run asynchronous reset of the 16-vector instance.
        #2;
        rst_mid = 1'b1;
        #1;
        check_val("mid_pre_finish", fin_s[6], 1'b0);
        #4;
        rst_mid = 1'b0;
        cyc = 0;
        for (int k = 0; k < 5; k++) tick();
        check_val("mid_run_a5", a_s[6] == 8'h09, 1'b0);
        #2;
        rst_mid = 1'b1;
        #1;
        check_val("mid_rst_a",      a_s[6],   8'h09);
        check_val("mid_rst_b",      b_s[6],   8'h0F);
        check_val("mid_rst_finish", fin_s[6], 1'b0);
        check_val("mid_rst_state",  st_s[6],  2'd0);
        @(posedge clock);
        #3;
        rst_mid = 1'b0;
        check_val("mid_c0_a", a_s[6], 8'h09);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) begin
                check_val("mid_c1_a", a_s[6], 8'hBC);
                check_val("mid_c1_b", b_s[6], 8'hBF);
            end
            if (k == 1) check_val("mid_c2_b", b_s[6], 8'hE7);
            if (k == 2) check_val("mid_c3_b", b_s[6], 8'hCB);
            if (k == 14) check_val("mid_finish_early", fin_s[6], 1'b0);
            if (k == 15) begin
                check_val("mid_finish", fin_s[6],  1'b1);
                check_val("mid_fail",   fail_s[6], 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vec_stim_check_i8.md
# vec_stim_check_i8

Self-checking stimulus sequencer for 8-bit, two-operand CI test designs. It sits directly upstream and downstream of a device under test (`lut_*_i8_i8_i8`, `dsp_*_i8_i8_i8`, and similar). It drives pseudo-random operand pairs `a`/`b` into the DUT, computes the golden result internally, and compares the DUT result `y` after a programmable latency. It reports through the same `fail`/`finish` pair every CI test exposes, so a multi-vector test replaces the hand-written single-step case test.

## Interface
- `OP`, default 0: golden operation. 0 = and, 1 = or, 2 = xor, 3 = add (mod 256), 4 = sub a-b (mod 256). Any other value is a lint error.
- `LATENCY`, default 0: DUT latency in cycles, legal range 0..7.
- `NUM_VEC`, default 16: number of vectors to apply, legal range 1..65535.
- `SEED_A`, default 8'h09: LFSR seed for `a`. A value of 0 is replaced by 8'h01.
- `SEED_B`, default 8'h0F: LFSR seed for `b`. A value of 0 is replaced by 8'h01.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high. Asserting it immediately forces every register to its reset value.
- `a`, output, 8: operand A to the DUT (registered).
- `b`, output, 8: operand B to the DUT (registered).
- `y`, input, 8: DUT result.
- `fail`, output, 1: sticky mismatch flag.
- `finish`, output, 1: sticky completion flag.
- `err_count`, output, 8: number of mismatches, saturates at 255.
- `first_err_idx`, output, 16: index of the first mismatching vector.

## Operation
- **LFSR:** 8-bit Galois with `next = s[0] ? (s>>1) ^ 8'hB8 : s>>1`. There is one LFSR per operand, and each advances once per applied vector.
- **State machine:** RUN → DRAIN → DONE.
  - RUN: `a`/`b` present vector i, with i = 0..NUM_VEC-1. On each rising edge the vector counter increments and both LFSRs advance. The expected value `exp = OP(a,b)` (8-bit wrap) and a valid bit are pushed into a LATENCY-deep delay line. The edge that consumes vector NUM_VEC-1 moves to DRAIN. `a`/`b` then hold their last value.
  - DRAIN: no new vectors. The delay line shifts in invalid entries. Moves to DONE once the last valid entry has been checked. When LATENCY = 0, DRAIN lasts zero cycles and the FSM goes RUN → DONE directly.
  - DONE: terminal. `finish` = 1 and holds until reset. No further checks occur and counters freeze.
- **Check:** on an edge where the delay-line head is valid (LATENCY = 0: the current RUN vector, compared combinationally), compare `y` with `exp`.
  - On mismatch: `fail` ← 1, `err_count` ← min(err_count+1, 255).
  - If this is the first mismatch, `first_err_idx` ← vector index.
  - The index travels with `exp` in the delay line.
- **Reset values:** `a` = SEED_A (0→1), `b` = SEED_B (0→1), `fail` = 0, `finish` = 0, `err_count` = 0, `first_err_idx` = 0. State = RUN, vector counter = 0, delay line all invalid.
- **Reset mid-operation:** all state is discarded. After release the sequence restarts at vector 0 with identical operands, so it is deterministic.
- `fail` and `err_count` never change after `finish` = 1.

## Timing
- Cycle k is the k-th rising edge after `reset` deasserts, starting at k = 0.
- Vector i is on `a`/`b` from after edge i-1 through edge i. Vector 0 is visible during reset and until edge 0.
- Vector i's `y` is sampled at edge i+LATENCY.
- `fail`/`err_count` update at the sampling edge and are visible one cycle later.
- `finish` rises at edge NUM_VEC+LATENCY-1, i.e. the same edge as the final check. `fail` is therefore final in the same cycle `finish` is first high.
- Simultaneous last check and mismatch: both `fail` and `finish` assert on that edge.
- There are no combinational paths from `y` to any output.

## Test plan
- **Single vector, AND:** `OP`=0, `LATENCY`=0, `NUM_VEC`=1, seeds 9/15, with `lut_and_i8_i8_i8` as the DUT. `a`=9, `b`=15, `y`=9. Required: `finish`=1 after edge 0, `fail`=0, `err_count`=0.
- **LFSR sequence:** `SEED_A`=8'h09. Required: `a` = 09, BC, 5E, 2F on cycles 0..3. `SEED_A`=0 gives `a`=01 then B8.
- **Injected mismatch:** `OP`=2, `LATENCY`=0, `NUM_VEC`=8, with a behavioural xor that forces `y`=0 on vector 3 only. Required: `fail`=1, `err_count`=1, `first_err_idx`=3, `finish` asserted at edge 7.
- **Latency:** `OP`=3, `LATENCY`=2, `NUM_VEC`=4, with a 2-stage registered adder DUT. Required: `fail`=0, `finish` rises at edge 5. Repeating with a 1-stage DUT gives `fail`=1 and `first_err_idx`=0.
- **Saturation:** `NUM_VEC`=300 with `y` tied to 0 and `OP`=4. Required: `err_count` stops at 255, `first_err_idx` equals the first vector where a≠b.
- **Reset mid-run:** assert `reset` asynchronously (between edges) at cycle 5 of 16. Required: outputs return to reset values immediately, and after release `a`/`b` repeat the cycle-0 sequence with `finish` at edge 15.
